// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: Moore datapath controls plus a retired-instruction counter.
// irWrite, pcWrite and illegalOp are the only outputs that also depend on inputs.
module multicycle_control #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [5:0]             opCode,
  input  logic                   zero,
  input  logic                   memReady,
  output logic                   pcWrite,
  output logic                   irWrite,
  output logic                   memRead,
  output logic                   memWrite,
  output logic                   iorD,
  output logic                   regWrite,
  output logic                   regDst,
  output logic                   memToReg,
  output logic                   aluSrcA,
  output logic [1:0]             aluSrcB,
  output logic [1:0]             aluOp,
  output logic [1:0]             pcSource,
  output logic                   illegalOp,
  output logic [3:0]             state,
  output logic [COUNT_WIDTH-1:0] retired
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic                   w_retire;
  logic [COUNT_WIDTH-1:0] r_retired;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + COUNT_WIDTH'(1);
    end
  end

  // Controls are gated by reset so FETCH's memRead cannot leak out while reset is held.
  always_comb begin
    w_next    = S_FETCH;
    w_retire  = 1'b0;
    pcWrite   = 1'b0;
    irWrite   = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    iorD      = 1'b0;
    regWrite  = 1'b0;
    regDst    = 1'b0;
    memToReg  = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = 2'b00;
    aluOp     = 2'b00;
    pcSource  = 2'b00;
    illegalOp = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          memRead = 1'b1;
          aluSrcB = 2'b01;
          irWrite = memReady;
          pcWrite = memReady;
          w_next  = memReady ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          aluSrcB = 2'b11;
          case (opCode)
            OP_RTYPE:      w_next = S_R_EXEC;
            OP_LW, OP_SW:  w_next = S_MEM_ADDR;
            OP_BEQ:        w_next = S_BRANCH;
            OP_J:          w_next = S_JUMP;
            OP_ADDI:       w_next = S_I_EXEC;
            default:       illegalOp = 1'b1;
          endcase
        end
        S_MEM_ADDR: begin
          aluSrcA = 1'b1;
          aluSrcB = 2'b10;
          w_next  = (opCode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        end
        S_MEM_READ: begin
          memRead = 1'b1;
          iorD    = 1'b1;
          w_next  = memReady ? S_MEM_WB : S_MEM_READ;
        end
        S_MEM_WB: begin
          regWrite = 1'b1;
          memToReg = 1'b1;
          w_retire = 1'b1;
        end
        S_MEM_WRITE: begin
          memWrite = 1'b1;
          iorD     = 1'b1;
          w_retire = memReady;
          w_next   = memReady ? S_FETCH : S_MEM_WRITE;
        end
        S_R_EXEC: begin
          aluSrcA = 1'b1;
          aluOp   = 2'b10;
          w_next  = S_R_WB;
        end
        S_R_WB: begin
          regWrite = 1'b1;
          regDst   = 1'b1;
          w_retire = 1'b1;
        end
        S_BRANCH: begin
          aluSrcA  = 1'b1;
          aluOp    = 2'b01;
          pcSource = 2'b01;
          pcWrite  = zero;
          w_retire = 1'b1;
        end
        S_JUMP: begin
          pcSource = 2'b10;
          pcWrite  = 1'b1;
          w_retire = 1'b1;
        end
        S_I_EXEC: begin
          aluSrcA = 1'b1;
          aluSrcB = 2'b10;
          w_next  = S_I_WB;
        end
        S_I_WB: begin
          regWrite = 1'b1;
          w_retire = 1'b1;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end

  assign state   = r_state;
  assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction stream against a per-instruction state-sequence model; a second
// instance with a 2-bit counter exercises wrap-around.
module tb_multicycle_control;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opCode = '0;
  logic        zero = 1'b0;
  logic        memReady = 1'b0;

  logic        pcWrite, irWrite, memRead, memWrite, iorD, regWrite, regDst, memToReg, aluSrcA;
  logic [1:0]  aluSrcB, aluOp, pcSource;
  logic        illegalOp;
  logic [3:0]  state;
  logic [15:0] retired;

  logic        s_pcWrite, s_irWrite, s_memRead, s_memWrite, s_iorD, s_regWrite, s_regDst;
  logic        s_memToReg, s_aluSrcA, s_illegalOp;
  logic [1:0]  s_aluSrcB, s_aluOp, s_pcSource;
  logic [3:0]  s_state;
  logic [1:0]  s_retired;

  int          n_vec = 0;
  int          n_bad = 0;
  int          exp_ret = 0;

  always #5 clock = ~clock;

  multicycle_control u_dut (
    .clock(clock), .reset(reset), .opCode(opCode), .zero(zero), .memReady(memReady),
    .pcWrite(pcWrite), .irWrite(irWrite), .memRead(memRead), .memWrite(memWrite),
    .iorD(iorD), .regWrite(regWrite), .regDst(regDst), .memToReg(memToReg),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSource(pcSource),
    .illegalOp(illegalOp), .state(state), .retired(retired)
  );

  multicycle_control #(.COUNT_WIDTH(2)) u_small (
    .clock(clock), .reset(reset), .opCode(opCode), .zero(zero), .memReady(memReady),
    .pcWrite(s_pcWrite), .irWrite(s_irWrite), .memRead(s_memRead), .memWrite(s_memWrite),
    .iorD(s_iorD), .regWrite(s_regWrite), .regDst(s_regDst), .memToReg(s_memToReg),
    .aluSrcA(s_aluSrcA), .aluSrcB(s_aluSrcB), .aluOp(s_aluOp), .pcSource(s_pcSource),
    .illegalOp(s_illegalOp), .state(s_state), .retired(s_retired)
  );

  wire [15:0] w_ctrl = {pcWrite, irWrite, memRead, memWrite, iorD, regWrite, regDst, memToReg,
                        aluSrcA, aluSrcB, aluOp, pcSource, illegalOp};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Control word expected in a given state, straight from the per-state output table.
  function automatic logic [15:0] exp_ctrl(input int s, input logic mr, input logic z,
                                           input logic legal);
    logic pw, iw, mrd, mw, iord, rw, rd, m2r, asa, ill;
    logic [1:0] asb, aop, psrc;
    {pw, iw, mrd, mw, iord, rw, rd, m2r, asa, ill} = '0;
    {asb, aop, psrc} = '0;
    case (s)
      0:  begin mrd = 1; asb = 2'b01; iw = mr; pw = mr; end
      1:  begin asb = 2'b11; ill = !legal; end
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'b01; psrc = 2'b01; pw = z; end
      9:  begin psrc = 2'b10; pw = 1; end
      10: begin asa = 1; asb = 2'b10; end
      11: begin rw = 1; end
      default: ;
    endcase
    return {pw, iw, mrd, mw, iord, rw, rd, m2r, asa, asb, aop, psrc, ill};
  endfunction

  // Builds the state walk an instruction should take and replays it cycle by cycle.
  task automatic run_instr(input logic [5:0] op, input int fwait, input int mwait,
                           input logic z);
    int   st[$];
    bit   mr[$];
    logic legal;
    legal = (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
            (op == OP_J) || (op == OP_ADDI);
    for (int k = 0; k < fwait; k++) begin st.push_back(0); mr.push_back(0); end
    st.push_back(0); mr.push_back(1);
    st.push_back(1); mr.push_back(0);
    case (op)
      OP_R:    begin st.push_back(6); st.push_back(7); end
      OP_LW:   begin
        st.push_back(2);
        for (int k = 0; k < mwait; k++) begin st.push_back(3); mr.push_back(0); end
        st.push_back(3); mr.push_back(1); st.push_back(4);
      end
      OP_SW:   begin
        st.push_back(2);
        for (int k = 0; k < mwait; k++) begin st.push_back(5); mr.push_back(0); end
        st.push_back(5); mr.push_back(1);
      end
      OP_BEQ:  st.push_back(8);
      OP_J:    st.push_back(9);
      OP_ADDI: begin st.push_back(10); st.push_back(11); end
      default: ;
    endcase
    // mr[] holds handshake values only for FETCH/MEM_READ/MEM_WRITE entries, in order.
    begin
      int hi = 0;
      for (int i = 0; i < st.size(); i++) begin
        logic m;
        if (st[i] == 0 || st[i] == 3 || st[i] == 5) begin
          m = mr[hi];
          hi++;
          if (st[i] == 0 && hi == fwait + 1) hi++;
        end else begin
          m = 1'($urandom);
        end
        opCode = op; zero = z; memReady = m;
        #2;
        check("state", 32'(state), 32'(st[i]));
        check("ctrl", 32'(w_ctrl), 32'(exp_ctrl(st[i], m, z, legal)));
        check("retired", 32'(retired), 32'(exp_ret & 16'hFFFF));
        check("retired_w2", 32'(s_retired), 32'(exp_ret % 4));
        @(posedge clock); #1;
        if (i == st.size() - 1 && legal) exp_ret++;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; memReady = 1'b1; opCode = OP_LW;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ctrl", 32'(w_ctrl), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    @(posedge clock); #1;
    check("rst_hold_ctrl", 32'(w_ctrl), 32'd0);
    reset = 1'b0;
    exp_ret = 0;
  endtask

  initial begin
    logic [5:0] ops [6];
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    #3;
    do_reset();

    run_instr(6'(32'h00221800 >> 26), 0, 0, 1'b0);
    check("r_retired_1", 32'(retired), 32'd1);
    run_instr(OP_LW, 0, 2, 1'b0);
    run_instr(OP_BEQ, 0, 0, 1'b1);
    run_instr(OP_BEQ, 1, 0, 1'b0);
    run_instr(6'b111111, 0, 0, 1'b0);
    check("illegal_no_retire", 32'(retired), 32'd4);
    run_instr(OP_SW, 2, 3, 1'b0);
    run_instr(OP_ADDI, 0, 0, 1'b1);

    // Asynchronous reset while MEM_WRITE is stalled.
    opCode = OP_SW; memReady = 1'b1;
    for (int k = 0; k < 3; k++) begin @(posedge clock); #1; end
    memReady = 1'b0;
    #2;
    check("abort_pre_state", 32'(state), 32'd5);
    check("abort_pre_memWrite", 32'(memWrite), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_memWrite", 32'(memWrite), 32'd0);
    check("abort_state", 32'(state), 32'd0);
    check("abort_retired", 32'(retired), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    exp_ret = 0;

    for (int k = 1; k <= 5; k++) begin
      run_instr(OP_J, 0, 0, 1'b0);
      check("wrap_w2", 32'(s_retired), 32'(k % 4));
    end

    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 9) == 0) begin
        op = 6'($urandom);
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
